// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JALRADR,
    S_JAL,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    IC_ADDI,
    IC_SLLI,
    IC_LW,
    IC_SW,
    IC_BEQ,
    IC_BNE,
    IC_JAL,
    IC_JALR,
    IC_NONE
  } iclass_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // First execution state for each instruction class leaving DECODE.
  function automatic state_t decode_target(iclass_t c);
    state_t s;
    case (c)
      IC_LW, IC_SW:    s = S_MEMADR;
      IC_ADDI, IC_SLLI: s = S_EXECI;
      IC_BEQ, IC_BNE:  s = S_BRANCH;
      IC_JAL:          s = S_JAL;
      IC_JALR:         s = S_JALRADR;
      default:         s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes out.
interface multicycle_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic [1:0] ResultSrc;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, funct3, funct7, Zero, mem_ready,
    output PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, ResultSrc, retire, illegal
  );

  modport slave (
    output op, funct3, funct7, Zero, mem_ready,
    input  PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, ResultSrc, retire, illegal
  );
endinterface

// File: rtl/mc_instr_decode.sv
// Classifies the instruction register fields into one of the supported
// instruction classes; anything unrecognised is IC_NONE / not legal.
module mc_instr_decode
  import multicycle_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output iclass_t    iclass,
  output logic       legal
);

  always_comb begin
    iclass = IC_NONE;
    case (op)
      OP_IMM: begin
        if (funct3 == 3'b000)                 iclass = IC_ADDI;
        else if (funct3 == 3'b001 && !funct7) iclass = IC_SLLI;
      end
      OP_LOAD:   if (funct3 == 3'b010) iclass = IC_LW;
      OP_STORE:  if (funct3 == 3'b010) iclass = IC_SW;
      OP_BRANCH: begin
        if (funct3 == 3'b000)      iclass = IC_BEQ;
        else if (funct3 == 3'b001) iclass = IC_BNE;
      end
      OP_JAL:    iclass = IC_JAL;
      OP_JALR:   if (funct3 == 3'b000) iclass = IC_JALR;
      default:   iclass = IC_NONE;
    endcase
    legal = (iclass != IC_NONE);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main sequencing FSM for the shared-datapath multicycle RISC-V core.
// state    | meaning
// RESET    | idle after rst, all strobes low
// FETCH    | read instruction at PC, PC+4 -> PC on mem_ready
// DECODE   | classify IR, speculative OldPC+imm -> ALUOut
// MEMADR   | rs1+imm address for lw/sw
// MEMREAD  | load access at ALUOut, wait for mem_ready
// MEMWB    | Data -> rd
// MEMWRITE | store access at ALUOut, retires on mem_ready
// EXECI    | rs1 op imm for addi/slli
// ALUWB    | ALUOut -> rd
// BRANCH   | rs1-rs2 compare, take ALUOut target on condition
// JALRADR  | rs1+imm target into ALUOut
// JAL      | ALUOut -> PC, OldPC+4 for link
// TRAP     | unsupported encoding, parked until rst
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  multicycle_if.master   bus
);

  state_t  state;
  logic    illegal_q;
  iclass_t iclass;
  logic    legal;

  mc_instr_decode u_decode (
    .op     (bus.op),
    .funct3 (bus.funct3),
    .funct7 (bus.funct7),
    .iclass (iclass),
    .legal  (legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RESET;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_RESET:    state <= S_FETCH;
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          state <= decode_target(iclass);
          if (!legal) illegal_q <= 1'b1;
        end
        S_MEMADR:   state <= (iclass == IC_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
        S_MEMWB,
        S_ALUWB,
        S_BRANCH:   state <= S_FETCH;
        S_EXECI:    state <= S_ALUWB;
        S_JALRADR:  state <= S_JAL;
        S_JAL:      state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_RESET;
      endcase
    end
  end

  assign bus.illegal = illegal_q;

  // Strobes decode from state; only the FETCH/BRANCH/MEMWRITE gates look at inputs.
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_RS2;
    bus.ALUControl = ALU_ADD;
    bus.ImmSrc     = IMM_I;
    bus.ResultSrc  = RES_ALUOUT;
    bus.retire     = 1'b0;
    case (state)
      S_FETCH: begin
        bus.MemRead   = 1'b1;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURES;
        bus.IRWrite   = bus.mem_ready;
        bus.PCWrite   = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = (bus.op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = (iclass == IC_SW) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        bus.AdrSrc  = 1'b1;
        bus.MemRead = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
        bus.retire    = 1'b1;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.retire   = bus.mem_ready;
      end
      S_EXECI: begin
        bus.ALUSrcA    = SRCA_RS1;
        bus.ALUSrcB    = SRCB_IMM;
        bus.ImmSrc     = IMM_I;
        bus.ALUControl = (iclass == IC_SLLI) ? ALU_SLL : ALU_ADD;
      end
      S_ALUWB: begin
        bus.ResultSrc = RES_ALUOUT;
        bus.RegWrite  = 1'b1;
        bus.retire    = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = SRCA_RS1;
        bus.ALUSrcB    = SRCB_RS2;
        bus.ALUControl = ALU_SUB;
        bus.ResultSrc  = RES_ALUOUT;
        bus.retire     = 1'b1;
        bus.PCWrite    = (iclass == IC_BNE) ? ~bus.Zero : bus.Zero;
      end
      S_JALRADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = IMM_I;
      end
      S_JAL: begin
        bus.ALUSrcA   = SRCA_OLDPC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALUOUT;
        bus.PCWrite   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction phase model predicts every cycle's strobes.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_if bus();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum {C_ADDI, C_SLLI, C_LW, C_SW, C_BEQ, C_BNE, C_JAL, C_JALR, C_ILL} cls_t;
  typedef enum {K_FW, K_FD, K_DEC, K_EXEC, K_WB, K_MADR, K_RDW, K_RDD, K_MWB,
                K_WRW, K_WRD, K_BR, K_JALR, K_JAL, K_TRAP} kind_t;

  typedef struct packed {
    logic       pcw, irw, adr, mrd, mwr, rw;
    logic [1:0] sa, sb;
    logic [2:0] alu, imm;
    logic [1:0] rs;
    logic       ret, ill;
  } ov_t;

  int checks = 0;
  int failures = 0;

  kind_t kind_q[$];
  ov_t   exp_q[$];
  ov_t   obs_q[$];

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;

  function automatic ov_t sample();
    ov_t o;
    o.pcw = bus.PCWrite;   o.irw = bus.IRWrite;  o.adr = bus.AdrSrc;
    o.mrd = bus.MemRead;   o.mwr = bus.MemWrite; o.rw  = bus.RegWrite;
    o.sa  = bus.ALUSrcA;   o.sb  = bus.ALUSrcB;  o.alu = bus.ALUControl;
    o.imm = bus.ImmSrc;    o.rs  = bus.ResultSrc;
    o.ret = bus.retire;    o.ill = bus.illegal;
    return o;
  endfunction

  // Strobes the datapath needs during each phase of an instruction.
  function automatic ov_t expect_out(kind_t k, cls_t c, logic zb);
    ov_t o = '0;
    case (k)
      K_FW, K_FD: begin
        o.mrd = 1; o.sa = 2'b00; o.sb = 2'b10; o.rs = 2'b10;
        if (k == K_FD) begin o.irw = 1; o.pcw = 1; end
      end
      K_DEC:  begin o.sa = 2'b01; o.sb = 2'b01; o.imm = (c == C_JAL) ? 3'b100 : 3'b010; end
      K_MADR: begin o.sa = 2'b10; o.sb = 2'b01; o.imm = (c == C_SW) ? 3'b001 : 3'b000; end
      K_RDW, K_RDD: begin o.adr = 1; o.mrd = 1; end
      K_MWB:  begin o.rs = 2'b01; o.rw = 1; o.ret = 1; end
      K_WRW, K_WRD: begin o.adr = 1; o.mwr = 1; o.ret = (k == K_WRD); end
      K_EXEC: begin o.sa = 2'b10; o.sb = 2'b01; o.alu = (c == C_SLLI) ? 3'b110 : 3'b000; end
      K_WB:   begin o.rw = 1; o.ret = 1; end
      K_BR: begin
        o.sa = 2'b10; o.alu = 3'b001; o.ret = 1;
        o.pcw = (c == C_BEQ) ? zb : ~zb;
      end
      K_JALR: begin o.sa = 2'b10; o.sb = 2'b01; end
      K_JAL:  begin o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1; end
      K_TRAP: o.ill = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic build_model(input cls_t c, input int wf, input int wm, input logic zb, input int ntrap);
    kind_q.delete();
    exp_q.delete();
    repeat (wf) kind_q.push_back(K_FW);
    kind_q.push_back(K_FD);
    kind_q.push_back(K_DEC);
    case (c)
      C_ADDI, C_SLLI: begin kind_q.push_back(K_EXEC); kind_q.push_back(K_WB); end
      C_LW: begin
        kind_q.push_back(K_MADR);
        repeat (wm) kind_q.push_back(K_RDW);
        kind_q.push_back(K_RDD);
        kind_q.push_back(K_MWB);
      end
      C_SW: begin
        kind_q.push_back(K_MADR);
        repeat (wm) kind_q.push_back(K_WRW);
        kind_q.push_back(K_WRD);
      end
      C_BEQ, C_BNE: kind_q.push_back(K_BR);
      C_JAL:  begin kind_q.push_back(K_JAL); kind_q.push_back(K_WB); end
      C_JALR: begin kind_q.push_back(K_JALR); kind_q.push_back(K_JAL); kind_q.push_back(K_WB); end
      default: repeat (ntrap) kind_q.push_back(K_TRAP);
    endcase
    foreach (kind_q[i]) exp_q.push_back(expect_out(kind_q[i], c, zb));
  endtask

  function automatic int base_latency(cls_t c);
    case (c)
      C_BEQ, C_BNE:               return 3;
      C_LW, C_JALR:               return 5;
      C_ADDI, C_SLLI, C_SW, C_JAL: return 4;
      default:                    return 0;
    endcase
  endfunction

  task automatic make_fields(input cls_t c);
    cur_f7 = 1'($urandom);
    cur_f3 = 3'($urandom);
    case (c)
      C_ADDI: begin cur_op = 7'b0010011; cur_f3 = 3'b000; end
      C_SLLI: begin cur_op = 7'b0010011; cur_f3 = 3'b001; cur_f7 = 1'b0; end
      C_LW:   begin cur_op = 7'b0000011; cur_f3 = 3'b010; end
      C_SW:   begin cur_op = 7'b0100011; cur_f3 = 3'b010; end
      C_BEQ:  begin cur_op = 7'b1100011; cur_f3 = 3'b000; end
      C_BNE:  begin cur_op = 7'b1100011; cur_f3 = 3'b001; end
      C_JAL:  cur_op = 7'b1101111;
      C_JALR: begin cur_op = 7'b1100111; cur_f3 = 3'b000; end
      default: begin cur_op = 7'b0110011; cur_f3 = 3'b000; cur_f7 = 1'b0; end
    endcase
  endtask

  // Drives one instruction through the DUT following the model's phase list.
  task automatic run_trace(input logic zb, input int abort_at);
    kind_t k;
    obs_q.delete();
    for (int i = 0; i < kind_q.size(); i++) begin
      @(posedge clk);
      #1;
      k = kind_q[i];
      if (k == K_FW || k == K_FD) begin
        bus.op = 7'($urandom); bus.funct3 = 3'($urandom); bus.funct7 = 1'($urandom);
      end else begin
        bus.op = cur_op; bus.funct3 = cur_f3; bus.funct7 = cur_f7;
      end
      if (k == K_FW || k == K_RDW || k == K_WRW)      bus.mem_ready = 1'b0;
      else if (k == K_FD || k == K_RDD || k == K_WRD) bus.mem_ready = 1'b1;
      else                                            bus.mem_ready = 1'($urandom);
      bus.Zero = (k == K_BR) ? zb : 1'($urandom);
      rst = (i == abort_at);
      @(negedge clk);
      obs_q.push_back(sample());
      if (i == abort_at) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic int first_retire();
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].ret) return i + 1;
    return -1;
  endfunction

  task automatic test_reset();
    ov_t o;
    do_reset();
    o = sample();
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", o);
    end
  endtask

  task automatic test_addi();
    int rw_n = 0;
    make_fields(C_ADDI);
    cur_f7 = 1'b0;
    build_model(C_ADDI, 0, 0, 1'b0, 0);
    run_trace(1'b0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL addi cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    foreach (obs_q[i]) rw_n += int'(obs_q[i].rw);
    checks++;
    if (rw_n != 1 || obs_q[3].rw !== 1'b1) begin
      failures++;
      $display("FAIL addi_regwrite count=%0d at3=%b exp count=1 at3=1", rw_n, obs_q[3].rw);
    end
    checks++;
    if (first_retire() != 4) begin
      failures++;
      $display("FAIL addi_latency got=%0d exp=4", first_retire());
    end
  endtask

  task automatic test_lw_wait();
    int held = 0;
    int wb_n = 0;
    make_fields(C_LW);
    build_model(C_LW, 0, 2, 1'b0, 0);
    run_trace(1'b0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL lw_wait cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    foreach (obs_q[i]) begin
      if (obs_q[i].adr && obs_q[i].mrd) held++;
      if (obs_q[i].rw && obs_q[i].rs == 2'b01) wb_n++;
    end
    checks++;
    if (held != 3 || wb_n != 1) begin
      failures++;
      $display("FAIL lw_hold held=%0d memwb=%0d exp held=3 memwb=1", held, wb_n);
    end
    checks++;
    if (first_retire() != 7) begin
      failures++;
      $display("FAIL lw_latency got=%0d exp=7", first_retire());
    end
  endtask

  task automatic test_branch();
    cls_t c;
    logic zb;
    for (int n = 0; n < 4; n++) begin
      c  = (n < 2) ? C_BEQ : C_BNE;
      zb = (n % 2 == 0) ? 1'b1 : 1'b0;
      make_fields(c);
      build_model(c, 0, 0, zb, 0);
      run_trace(zb, -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL branch%0d cyc%0d got=%h exp=%h", n, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (obs_q[2].pcw !== ((c == C_BEQ) ? zb : ~zb) || obs_q[2].alu !== 3'b001) begin
        failures++;
        $display("FAIL branch%0d_taken pcw=%b alu=%b zero=%b", n, obs_q[2].pcw, obs_q[2].alu, zb);
      end
    end
  endtask

  task automatic test_jumps();
    cls_t c;
    int pc_n;
    for (int n = 0; n < 2; n++) begin
      c = (n == 0) ? C_JAL : C_JALR;
      make_fields(c);
      build_model(c, 1, 0, 1'b0, 0);
      run_trace(1'b0, -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL jump%0d cyc%0d got=%h exp=%h", n, i, obs_q[i], exp_q[i]);
        end
      end
      pc_n = 0;
      foreach (obs_q[i]) pc_n += int'(obs_q[i].pcw);
      checks++;
      if (pc_n != 2 || first_retire() != base_latency(c) + 1) begin
        failures++;
        $display("FAIL jump%0d_pc pcwrites=%0d lat=%0d exp 2 and %0d", n, pc_n, first_retire(), base_latency(c) + 1);
      end
    end
  endtask

  task automatic test_trap();
    ov_t o;
    make_fields(C_ILL);
    build_model(C_ILL, 0, 0, 1'b0, 10);
    run_trace(1'b0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL trap cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    do_reset();
    o = sample();
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL trap_reset got=%h exp=0", o);
    end
    make_fields(C_ADDI);
    build_model(C_ADDI, 0, 0, 1'b0, 0);
    run_trace(1'b0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL trap_restart cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    ov_t o;
    make_fields(C_SW);
    build_model(C_SW, 0, 3, 1'b0, 0);
    run_trace(1'b0, 4);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL sw_abort cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    o = sample();
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL sw_abort_reset got=%h exp=0", o);
    end
  endtask

  task automatic test_back_to_back();
    cls_t c;
    int wf, wm, nret, lat;
    logic zb;
    for (int n = 0; n < 30; n++) begin
      c  = cls_t'($urandom_range(0, 7));
      wf = int'($urandom_range(0, 2));
      wm = int'($urandom_range(0, 2));
      zb = 1'($urandom);
      make_fields(c);
      build_model(c, wf, wm, zb, 0);
      run_trace(zb, -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL b2b%0d cls%0d cyc%0d got=%h exp=%h", n, c, i, obs_q[i], exp_q[i]);
        end
      end
      nret = 0;
      foreach (obs_q[i]) nret += int'(obs_q[i].ret);
      lat = base_latency(c) + wf + ((c == C_LW || c == C_SW) ? wm : 0);
      checks++;
      if (nret != 1 || first_retire() != lat) begin
        failures++;
        $display("FAIL b2b%0d_latency retires=%0d lat=%0d exp 1 and %0d", n, nret, first_retire(), lat);
      end
    end
  endtask

  initial begin
    bus.op = '0;
    bus.funct3 = '0;
    bus.funct7 = 1'b0;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_reset_mid_write();
    test_addi();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
